// File: rtl/dma_xfer_engine.sv
// dma_xfer_engine: single-channel DMA engine that copies a block of words
// between an IO-side and a memory-side address range over one master bus.
// Each word is one read request (RD) followed by one write request (WR).
// Optional build macro: DMA_XFER_ERR_EN adds the bus_err input and the
// sticky err output; a bus error aborts the remaining words of a transfer.

module dma_xfer_engine #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ctrl,
    input  logic [ADDR_WIDTH-1:0] io_addr,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic                  bus_wr_en,
    output logic                  bus_rd_en,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    input  logic                  bus_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  intr,
    input  logic                  intr_clr
`ifdef DMA_XFER_ERR_EN
    ,
    input  logic                  bus_err,
    output logic                  err
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    logic [ADDR_WIDTH-1:0] src_addr;
    logic [ADDR_WIDTH-1:0] dst_addr;
    logic [DATA_WIDTH-1:0] hold_data;
    logic [15:0]           count;

    logic        start;
    logic        dir;
    logic [15:0] length;
    logic        err_hit;
    logic        ctrl_unused;

    assign start       = ctrl[0];
    assign dir         = ctrl[1];
    assign length      = ctrl[31:16];
    assign ctrl_unused = ^ctrl[15:2];

`ifdef DMA_XFER_ERR_EN
    assign err_hit = bus_err;
`else
    assign err_hit = 1'b0;
`endif

    // State register; reset abandons any outstanding request immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and bus/status outputs, all derived from the current state.
    always_comb begin
        next_state = state;
        bus_addr   = '0;
        bus_rd_en  = 1'b0;
        bus_wr_en  = 1'b0;
        bus_wdata  = '0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (length == 16'd0) ? FIN : RD;
                end
            end
            RD: begin
                busy      = 1'b1;
                bus_rd_en = 1'b1;
                bus_addr  = src_addr;
                if (bus_ready) begin
                    next_state = err_hit ? FIN : WR;
                end
            end
            WR: begin
                busy      = 1'b1;
                bus_wr_en = 1'b1;
                bus_addr  = dst_addr;
                bus_wdata = hold_data;
                if (bus_ready) begin
                    if (err_hit || count == 16'd1) begin
                        next_state = FIN;
                    end else begin
                        next_state = RD;
                    end
                end
            end
            FIN: begin
                busy       = 1'b1;
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Transfer datapath: latch the job at start, capture read data, advance after each write.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_addr  <= '0;
            dst_addr  <= '0;
            hold_data <= '0;
            count     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        count    <= length;
                        src_addr <= dir ? mem_addr : io_addr;
                        dst_addr <= dir ? io_addr : mem_addr;
                    end
                end
                RD: begin
                    if (bus_ready) begin
                        hold_data <= bus_rdata;
                    end
                end
                WR: begin
                    if (bus_ready) begin
                        src_addr <= src_addr + ADDR_WIDTH'(4);
                        dst_addr <= dst_addr + ADDR_WIDTH'(4);
                        count    <= count - 16'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Sticky completion interrupt; a completion in the same cycle as a clear keeps it set.
    always_ff @(posedge clk) begin
        if (rst) begin
            intr <= 1'b0;
        end else if (state == FIN) begin
            intr <= 1'b1;
        end else if (intr_clr) begin
            intr <= 1'b0;
        end
    end

`ifdef DMA_XFER_ERR_EN
    // Sticky error flag raised by an accepted request that reported bus_err.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if ((state == RD || state == WR) && bus_ready && bus_err) begin
            err <= 1'b1;
        end else if (intr_clr) begin
            err <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_dma_xfer_engine.sv
// tb_dma_xfer_engine: directed tests for dma_xfer_engine. Expected bus
// requests are queued by the stimulus; a monitor compares every request the
// DUT presents against the head of the queue. The slave returns read data
// as a fixed function of the address so write data can be predicted.
// Define DMA_XFER_ERR_EN to also exercise the bus error abort.

module tb_dma_xfer_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ctrl;
    logic [31:0] io_addr;
    logic [31:0] mem_addr;
    logic [31:0] bus_addr;
    logic        bus_wr_en;
    logic        bus_rd_en;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ready;
    logic        busy;
    logic        done;
    logic        intr;
    logic        intr_clr;
`ifdef DMA_XFER_ERR_EN
    logic        bus_err;
    logic        err;
`endif

    typedef struct {
        bit          isWrite;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    txn_t expQ[$];
    txn_t head;
    int   checkCount = 0;
    int   errorCount = 0;
    int   rdEnCycles = 0;
    int   lat;

    always #5 clk = ~clk;

    dma_xfer_engine #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .ctrl     (ctrl),
        .io_addr  (io_addr),
        .mem_addr (mem_addr),
        .bus_addr (bus_addr),
        .bus_wr_en(bus_wr_en),
        .bus_rd_en(bus_rd_en),
        .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata),
        .bus_ready(bus_ready),
        .busy     (busy),
        .done     (done),
        .intr     (intr),
        .intr_clr (intr_clr)
`ifdef DMA_XFER_ERR_EN
        ,
        .bus_err  (bus_err),
        .err      (err)
`endif
    );

    function automatic logic [31:0] dataFor(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Slave memory model: read data depends only on the requested address.
    assign bus_rdata = dataFor(bus_addr);

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic void pushRead(input logic [31:0] a);
        txn_t t;
        t.isWrite = 1'b0;
        t.addr    = a;
        t.data    = 32'd0;
        expQ.push_back(t);
    endfunction

    function automatic void pushWrite(input logic [31:0] a, input logic [31:0] d);
        txn_t t;
        t.isWrite = 1'b1;
        t.addr    = a;
        t.data    = d;
        expQ.push_back(t);
    endfunction

    // Monitor: every presented request must match the queue head; pop on acceptance.
    always @(negedge clk) begin
        if (bus_rd_en === 1'b1 || bus_wr_en === 1'b1) begin
            checkOutput("rd_wr_exclusive", {31'd0, bus_rd_en & bus_wr_en}, 32'd0);
            if (expQ.size() == 0) begin
                checkOutput("unexpected_request", {30'd0, bus_rd_en, bus_wr_en}, 32'd0);
            end else begin
                head = expQ[0];
                checkOutput("req_is_write", {31'd0, bus_wr_en}, {31'd0, head.isWrite});
                checkOutput("req_addr", bus_addr, head.addr);
                if (head.isWrite) begin
                    checkOutput("wr_data", bus_wdata, head.data);
                end
                if (bus_ready === 1'b1) begin
                    void'(expQ.pop_front());
                end
            end
        end
        if (bus_rd_en === 1'b1) begin
            rdEnCycles++;
        end
    end

    // Present a start for one cycle, then scramble the programming inputs.
    task automatic applyStimulus(input logic [31:0] c, input logic [31:0] io, input logic [31:0] mem);
        @(posedge clk);
        #1;
        ctrl     = c;
        io_addr  = io;
        mem_addr = mem;
        @(posedge clk);
        #1;
        ctrl     = 32'hFFFF_0002;
        io_addr  = 32'hDEAD_0000;
        mem_addr = 32'hBEEF_0000;
    endtask

    // Count cycles until done, starting from the given number of elapsed cycles.
    task automatic waitDone(input int already, output int cycles);
        cycles = already;
        for (int i = 0; i < 60; i++) begin
            cycles++;
            @(negedge clk);
            if (done === 1'b1) return;
            @(posedge clk);
            #1;
        end
        cycles = -1;
    endtask

    task automatic pulseClear();
        @(posedge clk);
        #1;
        intr_clr = 1'b1;
        @(posedge clk);
        #1;
        intr_clr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        ctrl      = 32'd0;
        io_addr   = 32'd0;
        mem_addr  = 32'd0;
        bus_ready = 1'b1;
        intr_clr  = 1'b0;
`ifdef DMA_XFER_ERR_EN
        bus_err   = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_intr", {31'd0, intr}, 32'd0);
        checkOutput("rst_enables", {30'd0, bus_rd_en, bus_wr_en}, 32'd0);
        checkOutput("rst_bus_addr", bus_addr, 32'd0);
        checkOutput("rst_bus_wdata", bus_wdata, 32'd0);
`ifdef DMA_XFER_ERR_EN
        checkOutput("rst_err", {31'd0, err}, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] three-word io->mem transfer");
        pushRead(32'h100);  pushWrite(32'h2000, dataFor(32'h100));
        pushRead(32'h104);  pushWrite(32'h2004, dataFor(32'h104));
        pushRead(32'h108);  pushWrite(32'h2008, dataFor(32'h108));
        applyStimulus(32'h0003_0001, 32'h100, 32'h2000);
        checkOutput("busy_after_start", {31'd0, busy}, 32'd1);
        waitDone(0, lat);
        checkOutput("done_latency_3w", lat, 32'd7);
        @(posedge clk);
        @(negedge clk);
        checkOutput("intr_after_3w", {31'd0, intr}, 32'd1);
        checkOutput("busy_after_3w", {31'd0, busy}, 32'd0);
        checkOutput("done_single_pulse", {31'd0, done}, 32'd0);
        checkOutput("queue_empty_3w", expQ.size(), 32'd0);

        $display("[TB] mem->io single word with read stall");
        pulseClear();
        @(negedge clk);
        checkOutput("intr_cleared_1", {31'd0, intr}, 32'd0);
        bus_ready  = 1'b0;
        rdEnCycles = 0;
        pushRead(32'h4000); pushWrite(32'h300, dataFor(32'h4000));
        applyStimulus(32'h0001_0003, 32'h300, 32'h4000);
        repeat (3) @(posedge clk);
        #1;
        bus_ready = 1'b1;
        waitDone(3, lat);
        checkOutput("done_latency_stall", lat, 32'd6);
        checkOutput("rd_held_cycles", rdEnCycles, 32'd4);
        checkOutput("queue_empty_stall", expQ.size(), 32'd0);

        $display("[TB] zero-length transfer and start during completion");
        pulseClear();
        @(negedge clk);
        checkOutput("intr_cleared_2", {31'd0, intr}, 32'd0);
        applyStimulus(32'h0000_0001, 32'h800, 32'h9000);
        waitDone(0, lat);
        checkOutput("done_latency_len0", lat, 32'd1);
        ctrl = 32'h0001_0001;
        @(posedge clk);
        #1;
        ctrl = 32'd0;
        @(negedge clk);
        checkOutput("start_in_fin_ignored", {31'd0, busy}, 32'd0);
        checkOutput("intr_after_len0", {31'd0, intr}, 32'd1);

        $display("[TB] reset during second write of a four-word transfer");
        pushRead(32'h1000); pushWrite(32'hA000, dataFor(32'h1000));
        pushRead(32'h1004); pushWrite(32'hA004, dataFor(32'h1004));
        applyStimulus(32'h0004_0001, 32'h1000, 32'hA000);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_enables", {30'd0, bus_rd_en, bus_wr_en}, 32'd0);
        checkOutput("abort_intr", {31'd0, intr}, 32'd0);
        checkOutput("abort_done", {31'd0, done}, 32'd0);
        checkOutput("abort_queue", expQ.size(), 32'd0);
        pushRead(32'h1100); pushWrite(32'hB000, dataFor(32'h1100));
        pushRead(32'h1104); pushWrite(32'hB004, dataFor(32'h1104));
        applyStimulus(32'h0002_0001, 32'h1100, 32'hB000);
        waitDone(0, lat);
        checkOutput("done_latency_restart", lat, 32'd5);
        @(posedge clk);
        @(negedge clk);
        checkOutput("intr_after_restart", {31'd0, intr}, 32'd1);

        $display("[TB] address wrap and clear during completion");
        pulseClear();
        @(negedge clk);
        checkOutput("intr_cleared_3", {31'd0, intr}, 32'd0);
        pushRead(32'hFFFF_FFFC); pushWrite(32'h7000, dataFor(32'hFFFF_FFFC));
        pushRead(32'h0000_0000); pushWrite(32'h7004, dataFor(32'h0000_0000));
        applyStimulus(32'h0002_0001, 32'hFFFF_FFFC, 32'h7000);
        waitDone(0, lat);
        checkOutput("done_latency_wrap", lat, 32'd5);
        intr_clr = 1'b1;
        @(posedge clk);
        #1;
        intr_clr = 1'b0;
        @(negedge clk);
        checkOutput("intr_set_beats_clear", {31'd0, intr}, 32'd1);
        pulseClear();
        @(negedge clk);
        checkOutput("intr_cleared_4", {31'd0, intr}, 32'd0);
        checkOutput("queue_empty_wrap", expQ.size(), 32'd0);

`ifdef DMA_XFER_ERR_EN
        $display("[TB] bus error on first write");
        pushRead(32'h1200); pushWrite(32'hC000, dataFor(32'h1200));
        applyStimulus(32'h0003_0001, 32'h1200, 32'hC000);
        @(posedge clk);
        #1;
        bus_err = 1'b1;
        @(posedge clk);
        #1;
        bus_err = 1'b0;
        waitDone(2, lat);
        checkOutput("done_latency_err", lat, 32'd3);
        @(posedge clk);
        @(negedge clk);
        checkOutput("err_set", {31'd0, err}, 32'd1);
        checkOutput("intr_after_err", {31'd0, intr}, 32'd1);
        checkOutput("busy_after_err", {31'd0, busy}, 32'd0);
        checkOutput("queue_empty_err", expQ.size(), 32'd0);
        pulseClear();
        @(negedge clk);
        checkOutput("err_cleared", {31'd0, err}, 32'd0);
`endif

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
